// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory request/ready
// handshake, one-entry IF/ID register with stall, one-entry skid buffer,
// and branch/jump redirect handling with wrong-path squashing.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    output logic [31:0] ImemAddr,
    output logic        ImemReq,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] InstrOut,
    output logic [31:0] PcPlus4Out,
    output logic        InstrValid,
    output logic [5:0]  OpCodeOut
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SKID,
        DISCARD
    } fetchState_t;

    fetchState_t state;

    logic [31:0] skidInstr;
    logic [31:0] skidPcPlus4;
    logic [31:0] redirPc;
    logic [31:0] addrPlus4;
    logic [31:0] offsetShifted;
    logic        redir;
    logic [31:0] redirTarget;

    assign addrPlus4     = ImemAddr + 32'd4;
    assign offsetShifted = BranchOffset << 2;
    assign OpCodeOut     = InstrOut[31:26];

    // A redirect is only honoured for a live instruction that ID is consuming this cycle;
    // JR beats J, which beats a taken branch.
    always_comb begin
        redir       = 1'b0;
        redirTarget = PcPlus4Out + offsetShifted;
        if (InstrValid && !Stall) begin
            if (JumpReg) begin
                redir       = 1'b1;
                redirTarget = JumpRegTarget;
            end else if (Jump) begin
                redir       = 1'b1;
                redirTarget = {PcPlus4Out[31:28], InstrOut[25:0], 2'b00};
            end else if (Branch && BranchTaken) begin
                redir       = 1'b1;
                redirTarget = PcPlus4Out + offsetShifted;
            end
        end
    end

    // Fetch FSM: owns the PC, the request line, the IF/ID register and the skid buffer.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            ImemAddr    <= RESET_PC;
            ImemReq     <= 1'b0;
            InstrOut    <= 32'd0;
            PcPlus4Out  <= 32'd0;
            InstrValid  <= 1'b0;
            skidInstr   <= 32'd0;
            skidPcPlus4 <= 32'd0;
            redirPc     <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    ImemReq <= 1'b1;
                end

                FETCH: begin
                    if (ImemReady) begin
                        if (redir) begin
                            ImemAddr   <= redirTarget;
                            redirPc    <= redirTarget;
                            InstrValid <= 1'b0;
                        end else if (!Stall) begin
                            InstrOut   <= ImemData;
                            PcPlus4Out <= addrPlus4;
                            InstrValid <= 1'b1;
                            ImemAddr   <= addrPlus4;
                        end else begin
                            skidInstr   <= ImemData;
                            skidPcPlus4 <= addrPlus4;
                            ImemAddr    <= addrPlus4;
                            state       <= SKID;
                            ImemReq     <= 1'b0;
                        end
                    end else begin
                        if (redir) begin
                            redirPc    <= redirTarget;
                            InstrValid <= 1'b0;
                            state      <= DISCARD;
                        end else if (!Stall) begin
                            InstrValid <= 1'b0;
                        end
                    end
                end

                SKID: begin
                    if (!Stall) begin
                        if (redir) begin
                            ImemAddr   <= redirTarget;
                            redirPc    <= redirTarget;
                            InstrValid <= 1'b0;
                        end else begin
                            InstrOut   <= skidInstr;
                            PcPlus4Out <= skidPcPlus4;
                            InstrValid <= 1'b1;
                        end
                        state   <= FETCH;
                        ImemReq <= 1'b1;
                    end
                end

                DISCARD: begin
                    if (ImemReady) begin
                        ImemAddr <= redirPc;
                        state    <= FETCH;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ImemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule
